// File: rtl/sma_pkg.sv
// Shared types and widths for the SMA crossover signal generator.
package sma_pkg;

  localparam int unsigned PRICE_W = 8;
  localparam int unsigned DIFF_W  = PRICE_W + 1;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned WCNT_W  = 8;

  typedef enum logic [1:0] {
    POS_FLAT  = 2'b00,
    POS_LONG  = 2'b01,
    POS_SHORT = 2'b10
  } position_t;

  typedef enum logic [1:0] {
    ST_WARMUP = 2'b00,
    ST_FLAT   = 2'b01,
    ST_LONG   = 2'b10,
    ST_SHORT  = 2'b11
  } xover_state_t;

  typedef enum logic [1:0] {
    CLS_BAND  = 2'b00,
    CLS_ABOVE = 2'b01,
    CLS_BELOW = 2'b10
  } cls_t;

  // Warm-up is reported as FLAT so the position bus never carries 2'b11.
  function automatic position_t state_to_pos(input xover_state_t s);
    position_t p;
    p = POS_FLAT;
    case (s)
      ST_LONG:  p = POS_LONG;
      ST_SHORT: p = POS_SHORT;
      default:  p = POS_FLAT;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/sma_diff_cmp.sv
// Signed fast-minus-slow difference classified against a symmetric dead band.
module sma_diff_cmp
  import sma_pkg::*;
#(
  parameter int unsigned HYST = 2
) (
  input  logic [PRICE_W-1:0] fast_avg,
  input  logic [PRICE_W-1:0] slow_avg,
  output cls_t               cls_c
);

  localparam logic signed [DIFF_W-1:0] HYST_S = DIFF_W'(HYST);

  logic signed [DIFF_W-1:0] diff;

  // One extra bit keeps the full -255..+255 range without overflow.
  assign diff = $signed({1'b0, fast_avg}) - $signed({1'b0, slow_avg});

  always_comb begin
    cls_c = CLS_BAND;
    if (diff > HYST_S) begin
      cls_c = CLS_ABOVE;
    end else if (diff < -HYST_S) begin
      cls_c = CLS_BELOW;
    end
  end

endmodule

// File: rtl/sma_crossover_signal.sv
// Crossover trading FSM: warm-up, long/short/flat position tracking,
// post-trade cooldown and a saturating trade counter.
module sma_crossover_signal
  import sma_pkg::*;
#(
  parameter int unsigned HYST     = 2,
  parameter int unsigned WARMUP   = 8,
  parameter int unsigned COOLDOWN = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PRICE_W-1:0] fast_avg,
  input  logic [PRICE_W-1:0] slow_avg,
  input  logic               avg_valid,
  input  logic               flat_req,
  output logic               buy_pulse,
  output logic               sell_pulse,
  output logic [1:0]         position,
  output logic               ready,
  output logic [CNT_W-1:0]   trade_count
);

  xover_state_t      state_q, state_d;
  logic [WCNT_W-1:0] warm_q, warm_d;
  logic [WCNT_W-1:0] cool_q, cool_d;
  logic [CNT_W-1:0]  count_d;
  logic              buy_d, sell_d, ready_d, act;
  position_t         pos_d;
  cls_t              cls;

  sma_diff_cmp #(.HYST(HYST)) u_cmp (
    .fast_avg (fast_avg),
    .slow_avg (slow_avg),
    .cls_c    (cls)
  );

  // Crossings are acted on only with a valid sample, no flat request and no cooldown.
  assign act = avg_valid && !flat_req && (cool_q == '0);

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    cool_d  = (cool_q != '0) ? cool_q - WCNT_W'(1) : '0;
    count_d = trade_count;
    ready_d = ready;
    buy_d   = 1'b0;
    sell_d  = 1'b0;

    unique case (state_q)
      ST_WARMUP: begin
        if (avg_valid) begin
          warm_d = warm_q + WCNT_W'(1);
          if (warm_q == WCNT_W'(WARMUP - 1)) begin
            state_d = ST_FLAT;
            ready_d = 1'b1;
          end
        end
      end
      ST_FLAT: begin
        if (act && cls == CLS_ABOVE) begin
          state_d = ST_LONG;
          buy_d   = 1'b1;
        end else if (act && cls == CLS_BELOW) begin
          state_d = ST_SHORT;
          sell_d  = 1'b1;
        end
      end
      ST_LONG: begin
        if (flat_req) begin
          state_d = ST_FLAT;
          sell_d  = 1'b1;
        end else if (act && cls == CLS_BELOW) begin
          state_d = ST_SHORT;
          sell_d  = 1'b1;
        end
      end
      ST_SHORT: begin
        if (flat_req) begin
          state_d = ST_FLAT;
          buy_d   = 1'b1;
        end else if (act && cls == CLS_ABOVE) begin
          state_d = ST_LONG;
          buy_d   = 1'b1;
        end
      end
      default: state_d = ST_WARMUP;
    endcase

    // Every trade restarts the cooldown and bumps the saturating counter.
    if (buy_d || sell_d) begin
      cool_d = WCNT_W'(COOLDOWN);
      if (trade_count != '1) begin
        count_d = trade_count + CNT_W'(1);
      end
    end

    pos_d = state_to_pos(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_WARMUP;
      warm_q      <= '0;
      cool_q      <= '0;
      trade_count <= '0;
      ready       <= 1'b0;
      buy_pulse   <= 1'b0;
      sell_pulse  <= 1'b0;
      position    <= POS_FLAT;
    end else begin
      state_q     <= state_d;
      warm_q      <= warm_d;
      cool_q      <= cool_d;
      trade_count <= count_d;
      ready       <= ready_d;
      buy_pulse   <= buy_d;
      sell_pulse  <= sell_d;
      position    <= pos_d;
    end
  end

endmodule

// File: tb/tb_sma_crossover_signal.sv
// Scoreboard bench for sma_crossover_signal: directed vectors push expectations,
// a monitor pops and compares one entry per clock.
module tb_sma_crossover_signal;
  import sma_pkg::*;

  localparam logic [1:0] F = 2'b00;
  localparam logic [1:0] L = 2'b01;
  localparam logic [1:0] S = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  fast_avg = '0, slow_avg = '0;
  logic        avg_valid = 1'b0, flat_req = 1'b0;
  logic        buy_pulse, sell_pulse, ready;
  logic [1:0]  position;
  logic [15:0] trade_count;

  logic [7:0]  fast2 = '0, slow2 = '0;
  logic        valid2 = 1'b0, flat2 = 1'b0;
  logic        buy2, sell2, ready2;
  logic [1:0]  pos2;
  logic [15:0] count2;

  always #5 clk = ~clk;

  sma_crossover_signal dut (
    .clk(clk), .rst_n(rst_n), .fast_avg(fast_avg), .slow_avg(slow_avg),
    .avg_valid(avg_valid), .flat_req(flat_req), .buy_pulse(buy_pulse),
    .sell_pulse(sell_pulse), .position(position), .ready(ready),
    .trade_count(trade_count)
  );

  sma_crossover_signal #(.HYST(2), .WARMUP(1), .COOLDOWN(0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .fast_avg(fast2), .slow_avg(slow2),
    .avg_valid(valid2), .flat_req(flat2), .buy_pulse(buy2),
    .sell_pulse(sell2), .position(pos2), .ready(ready2),
    .trade_count(count2)
  );

  typedef struct {
    bit          sel;
    logic        buy;
    logic        sell;
    logic [1:0]  pos;
    logic        rdy;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each clock, compare the oldest expectation against the selected DUT.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (!e.sel) begin
          chk("buy", 32'(buy_pulse), 32'(e.buy));
          chk("sell", 32'(sell_pulse), 32'(e.sell));
          chk("pos", 32'(position), 32'(e.pos));
          chk("ready", 32'(ready), 32'(e.rdy));
          chk("count", 32'(trade_count), 32'(e.cnt));
        end else begin
          chk("sat_buy", 32'(buy2), 32'(e.buy));
          chk("sat_sell", 32'(sell2), 32'(e.sell));
          chk("sat_pos", 32'(pos2), 32'(e.pos));
          chk("sat_ready", 32'(ready2), 32'(e.rdy));
          chk("sat_count", 32'(count2), 32'(e.cnt));
        end
      end
    end
  end

  task automatic step(input logic v, input logic [7:0] f, input logic [7:0] s, input logic fr,
                      input logic eb, input logic es, input logic [1:0] ep,
                      input logic er, input logic [15:0] ec);
    @(negedge clk);
    avg_valid = v; fast_avg = f; slow_avg = s; flat_req = fr;
    q.push_back('{1'b0, eb, es, ep, er, ec});
  endtask

  task automatic step_sat(input logic v, input logic [7:0] f, input logic [7:0] s, input bit push,
                          input logic eb, input logic es, input logic [1:0] ep,
                          input logic er, input logic [15:0] ec);
    @(negedge clk);
    valid2 = v; fast2 = f; slow2 = s;
    if (push) q.push_back('{1'b1, eb, es, ep, er, ec});
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    #12;
    chk("rst_pos", 32'(position), 32'(F));
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_count", 32'(trade_count), 32'd0);
    chk("rst_pulses", 32'({buy_pulse, sell_pulse}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Warm-up: flat_req ignored, invalid cycle freezes the count.
    step(1, 100, 50, 1, 0, 0, F, 0, 0);
    step(1, 100, 50, 0, 0, 0, F, 0, 0);
    step(1, 100, 50, 0, 0, 0, F, 0, 0);
    step(0, 100, 50, 0, 0, 0, F, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 100, 50, 0, 0, 0, F, 0, 0);
    step(1, 100, 50, 0, 0, 0, F, 1, 0);
    step(1, 100, 50, 0, 1, 0, L, 1, 1);

    // Cooldown: BELOW one cycle after the buy is dropped; five cycles after it fires.
    step(1, 50, 53, 0, 0, 0, L, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 50, 53, 0, 0, 0, L, 1, 1);
    step(1, 50, 53, 0, 0, 1, S, 1, 2);

    // flat_req in SHORT with ABOVE during cooldown; cooldown reloads.
    step(1, 100, 50, 1, 1, 0, F, 1, 3);
    for (int i = 0; i < 4; i++) step(1, 100, 50, 0, 0, 0, F, 1, 3);
    step(1, 100, 50, 0, 1, 0, L, 1, 4);

    // Hysteresis edges: -2 holds LONG, -3 sells; +2 holds SHORT, +3 buys.
    for (int i = 0; i < 5; i++) step(1, 50, 52, 0, 0, 0, L, 1, 4);
    step(1, 50, 53, 0, 0, 1, S, 1, 5);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, S, 1, 5);
    step(1, 52, 50, 0, 0, 0, S, 1, 5);
    step(1, 53, 50, 0, 1, 0, L, 1, 6);

    // Extreme differences and flat_req without a valid sample.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, L, 1, 6);
    step(1, 0, 255, 0, 0, 1, S, 1, 7);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, S, 1, 7);
    step(0, 0, 0, 1, 1, 0, F, 1, 8);
    step(0, 0, 0, 1, 0, 0, F, 1, 8);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, F, 1, 8);
    step(1, 255, 0, 0, 1, 0, L, 1, 9);
    step(0, 0, 0, 0, 0, 0, L, 1, 9);

    // Asynchronous reset between edges while in LONG with cooldown running.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_pos", 32'(position), 32'(F));
    chk("arst_count", 32'(trade_count), 32'd0);
    chk("arst_ready", 32'(ready), 32'd0);
    chk("arst_pulses", 32'({buy_pulse, sell_pulse}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) step(1, 100, 50, 0, 0, 0, F, 0, 0);
    step(1, 100, 50, 0, 0, 0, F, 1, 0);
    step(1, 100, 50, 0, 1, 0, L, 1, 1);
    step(0, 0, 0, 0, 0, 0, L, 1, 1);

    // Saturation on the zero-cooldown instance: 65537 alternating trades.
    step_sat(1, 100, 50, 1'b1, 0, 0, F, 1, 0);
    for (int k = 1; k <= 65537; k++) begin
      bit odd;
      odd = (k % 2) == 1;
      step_sat(1, odd ? 8'd100 : 8'd50, odd ? 8'd50 : 8'd53,
               (k <= 3) || (k >= 65533),
               odd, !odd, odd ? L : S, 1, (k > 65535) ? 16'hFFFF : 16'(k));
    end
    step_sat(0, 0, 0, 1'b1, 0, 0, L, 1, 16'hFFFF);
    @(negedge clk);
    valid2 = 1'b0;

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sma_crossover_signal.md
SMA_CROSSOVER_SIGNAL -- requirements
Module: sma_crossover_signal

Interface
REQ-001 Parameter HYST, default 2: dead-band half-width in price LSBs; legal range 0..127.
REQ-002 Parameter WARMUP, default 8: number of valid samples ignored after reset; legal range 1..255.
REQ-003 Parameter COOLDOWN, default 4: clock cycles during which crossings are ignored after any trade; legal range 0..255.
REQ-004 clk  in  1: single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1: reset, asynchronous, active-low.
REQ-006 fast_avg  in  8: unsigned fast moving-average price, from the upstream SMA stage.
REQ-007 slow_avg  in  8: unsigned slow moving-average price, from the upstream SMA stage.
REQ-008 avg_valid  in  1: fast_avg and slow_avg are a valid sample pair this cycle.
REQ-009 flat_req  in  1: request to close any open position.
REQ-010 buy_pulse  out  1: one-cycle buy order strobe.
REQ-011 sell_pulse  out  1: one-cycle sell order strobe.
REQ-012 position  out  2: current position; 00 = FLAT, 01 = LONG, 10 = SHORT; 11 is never driven.
REQ-013 ready  out  1: high once warm-up is complete.
REQ-014 trade_count  out  16: number of emitted pulses, saturating.

Function
REQ-015 Compute diff = fast_avg - slow_avg as 9-bit signed, with no overflow.
REQ-016 Classify each sample:
- ABOVE when diff > +HYST.
- BELOW when diff < -HYST.
- otherwise BAND.
REQ-017 FSM states are WARMUP, FLAT, LONG, SHORT; reset state is WARMUP.
REQ-018 WARMUP:
- Count avg_valid cycles in an 8-bit counter.
- On the WARMUP-th valid cycle, go to FLAT with no pulse.
- ready goes high in the same edge as that transition.
REQ-019 In FLAT, LONG and SHORT, act only on cycles with avg_valid=1, flat_req=0 and cooldown counter = 0:
- FLAT + ABOVE -> LONG, buy_pulse.
- FLAT + BELOW -> SHORT, sell_pulse.
- LONG + BELOW -> SHORT, sell_pulse.
- SHORT + ABOVE -> LONG, buy_pulse.
- All other combinations hold state with no pulse.
REQ-020 BAND never changes state; hysteresis is implicit.
REQ-021 flat_req=1 in LONG -> FLAT with sell_pulse; in SHORT -> FLAT with buy_pulse; in FLAT -> no action.
REQ-022 In WARMUP, flat_req is ignored.
REQ-023 flat_req overrides the cooldown counter and overrides avg_valid.
REQ-024 Latency: pulses, position and trade_count update registered, one clock after the deciding input cycle.
REQ-025 buy_pulse and sell_pulse are never high together, and each is high for exactly one cycle per trade.
REQ-026 Cooldown:
- On any pulse-emitting edge, load the cooldown counter with COOLDOWN.
- Otherwise decrement while nonzero, once per clock.
- COOLDOWN=0 disables the cooldown.
REQ-027 A crossing suppressed by the cooldown is not remembered; it fires only if it persists on a valid sample after the counter reaches 0.
REQ-028 trade_count increments by 1 per pulse and saturates at 16'hFFFF; it never wraps.
REQ-029 avg_valid=0 freezes the warm-up count and the FSM; the cooldown counter still decrements.

Reset
REQ-030 Asserting rst_n=0 immediately clears all of the following, including mid-cooldown and mid-warm-up:
- state -> WARMUP.
- position, buy_pulse, sell_pulse, ready -> 0.
- trade_count, warm-up counter, cooldown counter -> 0.
REQ-031 After rst_n deasserts, the first edge takes effect normally; no trade pulse is generated by reset itself.

Structure
REQ-032 A shared package sma_pkg holds:
- the position_t enum (FLAT/LONG/SHORT, 2-bit).
- the xover_state_t enum.
- PRICE_W = 8.
REQ-033 One sub-module, sma_diff_cmp, is natural: combinational signed subtract plus HYST classification, outputting ABOVE/BELOW/BAND.
REQ-034 The FSM, counters and output registers live in sma_crossover_signal.

Verification
REQ-035 The bench covers at least the following directed scenarios (default parameters, HYST=2, WARMUP=8, COOLDOWN=4).
REQ-036 Warm-up: 7 valid samples with fast=100, slow=50 -> position=00, no pulse, ready=0. 8th sample -> ready=1, position=00, no pulse. 9th sample -> buy_pulse for 1 cycle, position=01, trade_count=1.
REQ-037 Hysteresis, in LONG: fast=50, slow=52 (diff -2, BAND) -> hold LONG. fast=50, slow=53 (diff -3) -> sell_pulse, position=10.
REQ-038 Cooldown: BELOW sample 1 cycle after a buy -> ignored. Same BELOW sample 5 cycles after the buy -> sell_pulse.
REQ-039 flat_req in SHORT together with avg_valid ABOVE, cooldown active -> buy_pulse, position=00, cooldown reloaded.
REQ-040 Saturation: force 65537 alternating trades -> trade_count holds at 16'hFFFF.
REQ-041 Async reset: pull rst_n low mid-cooldown in LONG, between clock edges -> position=00 and trade_count=0 without waiting for a clock edge; warm-up restarts.
